// File: rtl/enemy_lifecycle_if.sv
// enemy_lifecycle_if: pixel/collision/spawn request bundle plus sprite, score and liveness results
interface enemy_lifecycle_if #(
  parameter int ENEMY_NUM   = 4,
  parameter int IDX_W       = 2,
  parameter int DOWN_FRAMES = 3,
  parameter int GRAY_W      = 4,
  parameter int SCORE_W     = 3
);
  logic                                  vali_i;
  logic [IDX_W-1:0]                      curr_idx_i;
  logic                                  hit_i;
  logic                                  crash_me_i;
  logic                                  bomb_i;
  logic                                  trigger_i;
  logic [IDX_W-1:0]                      trigger_idx_i;
  logic [(DOWN_FRAMES+2)*(1+GRAY_W)-1:0] sprite_i;
  logic                                  vga_alpha_o;
  logic [3*GRAY_W-1:0]                   vga_rgb_o;
  logic [ENEMY_NUM-1:0]                  disappear_o;
  logic [SCORE_W-1:0]                    add_score_o;
  logic [ENEMY_NUM-1:0]                  live_o;
  modport master (
    output vali_i, curr_idx_i, hit_i, crash_me_i, bomb_i, trigger_i, trigger_idx_i, sprite_i,
    input  vga_alpha_o, vga_rgb_o, disappear_o, add_score_o, live_o
  );
  modport slave (
    input  vali_i, curr_idx_i, hit_i, crash_me_i, bomb_i, trigger_i, trigger_idx_i, sprite_i,
    output vga_alpha_o, vga_rgb_o, disappear_o, add_score_o, live_o
  );
endinterface

// File: rtl/enemy_lifecycle.sv
// enemy_lifecycle: per-slot enemy spawn/damage/explosion FSMs, sprite pixel select and score; define ENEMY_HIT_FLASH_EN for the hit-flash state
module enemy_lifecycle #(
  parameter int ENEMY_NUM    = 4,
  parameter int IDX_W        = 2,
  parameter int HP           = 3,
  parameter int HP_W         = 2,
  parameter int DOWN_FRAMES  = 3,
  parameter int CNT_DOWN_MAX = 1000000,
  parameter int CNT_W        = 20,
  parameter int GRAY_W       = 4,
  parameter int SCORE_W      = 3
) (
  input logic              clk_vga,
  input logic              rst,
  enemy_lifecycle_if.slave bus
);
  localparam int FW    = 1 + GRAY_W;
  localparam int FR_W  = DOWN_FRAMES > 1 ? $clog2(DOWN_FRAMES) : 1;
  localparam int POP_W = $clog2(ENEMY_NUM + 1);
`ifdef ENEMY_HIT_FLASH_EN
  localparam bit HIT_FLASH = 1'b1;
`else
  localparam bit HIT_FLASH = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_NORMAL, S_HIT, S_DOWN} state_t;
  state_t               r_state     [ENEMY_NUM];
  state_t               w_state_nxt [ENEMY_NUM];
  logic [HP_W-1:0]      r_hp        [ENEMY_NUM];
  logic [HP_W-1:0]      w_hp_nxt    [ENEMY_NUM];
  logic [FR_W-1:0]      r_frame     [ENEMY_NUM];
  logic [FR_W-1:0]      w_frame_nxt [ENEMY_NUM];
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_tick;
  logic [ENEMY_NUM-1:0] w_live;
  logic [ENEMY_NUM-1:0] w_addr;
  logic [ENEMY_NUM-1:0] w_kill;
  logic [ENEMY_NUM-1:0] w_disappear;
  logic [POP_W-1:0]     w_pop;
  state_t               w_sel_state;
  logic [FR_W-1:0]      w_sel_frame;
  logic [FW-1:0]        w_down;
  logic [FW-1:0]        w_field;

  // frame-rate divider: tick is high for the single cycle following each wrap
  always_ff @(posedge clk_vga or posedge rst)
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= r_cnt == CNT_W'(CNT_DOWN_MAX - 1);
      r_cnt  <= r_cnt == CNT_W'(CNT_DOWN_MAX - 1) ? '0 : r_cnt + CNT_W'(1);
    end

  // slot state registers
  always_ff @(posedge clk_vga or posedge rst)
    if (rst) begin
      r_state <= '{default: S_IDLE};
      r_hp    <= '{default: '0};
      r_frame <= '{default: '0};
    end else begin
      r_state <= w_state_nxt;
      r_hp    <= w_hp_nxt;
      r_frame <= w_frame_nxt;
    end

  // per-slot next state: spawn, kill (bomb > crash > fatal hit), damage, flash recovery, explosion frames
  always_comb begin
    for (int s = 0; s < ENEMY_NUM; s++) begin
      w_state_nxt[s] = r_state[s];
      w_hp_nxt[s]    = r_hp[s];
      w_frame_nxt[s] = r_frame[s];
      w_live[s]      = r_state[s] == S_NORMAL || r_state[s] == S_HIT;
      w_addr[s]      = bus.vali_i && bus.curr_idx_i == IDX_W'(s) && int'(bus.curr_idx_i) < ENEMY_NUM;
      w_kill[s]      = w_live[s] && (bus.bomb_i || w_addr[s] && (bus.crash_me_i || bus.hit_i && r_hp[s] == HP_W'(1)));
      w_disappear[s] = r_state[s] == S_DOWN && r_tick && r_frame[s] == FR_W'(DOWN_FRAMES - 1);
      if (r_state[s] == S_IDLE && bus.trigger_i && bus.trigger_idx_i == IDX_W'(s)) begin
        w_state_nxt[s] = S_NORMAL;
        w_hp_nxt[s]    = HP_W'(HP);
        w_frame_nxt[s] = '0;
      end else if (w_kill[s]) begin
        w_state_nxt[s] = S_DOWN;
        w_hp_nxt[s]    = '0;
        w_frame_nxt[s] = '0;
      end else if (w_live[s] && w_addr[s] && bus.hit_i) begin
        w_state_nxt[s] = HIT_FLASH ? S_HIT : S_NORMAL;
        w_hp_nxt[s]    = r_hp[s] - HP_W'(1);
      end else if (r_state[s] == S_HIT && r_tick) begin
        w_state_nxt[s] = S_NORMAL;
      end else if (r_state[s] == S_DOWN && r_tick) begin
        w_state_nxt[s] = w_disappear[s] ? S_IDLE : S_DOWN;
        w_frame_nxt[s] = w_disappear[s] ? '0 : r_frame[s] + FR_W'(1);
      end
    end
  end

  // zero-latency sprite field select for the slot owning the current pixel
  always_comb begin
    w_sel_state = S_IDLE;
    w_sel_frame = '0;
    w_down      = '0;
    for (int s = 0; s < ENEMY_NUM; s++)
      if (bus.vali_i && bus.curr_idx_i == IDX_W'(s)) begin
        w_sel_state = r_state[s];
        w_sel_frame = r_frame[s];
      end
    for (int k = 0; k < DOWN_FRAMES; k++)
      if (w_sel_frame == FR_W'(k)) w_down = bus.sprite_i[(DOWN_FRAMES - 1 - k) * FW +: FW];
    w_field = w_sel_state == S_NORMAL ? bus.sprite_i[(DOWN_FRAMES + 1) * FW +: FW] :
              (HIT_FLASH && w_sel_state == S_HIT) ? bus.sprite_i[DOWN_FRAMES * FW +: FW] :
              w_sel_state == S_DOWN ? w_down : '0;
  end

  // score: number of explosions finishing this cycle, saturated
  always_comb begin
    w_pop = '0;
    for (int s = 0; s < ENEMY_NUM; s++) w_pop = w_pop + POP_W'(w_disappear[s]);
    bus.add_score_o = int'(w_pop) > 2 ** SCORE_W - 1 ? '1 : SCORE_W'(w_pop);
  end

  assign bus.vga_alpha_o = w_field[FW-1];
  assign bus.vga_rgb_o   = {3{w_field[GRAY_W-1:0]}};
  assign bus.disappear_o = w_disappear;
  assign bus.live_o      = w_live;
endmodule

// File: doc/enemy_lifecycle.md
ENEMY_LIFECYCLE -- requirements
Module: enemy_lifecycle

Interface
REQ-001 SHALL have parameter ENEMY_NUM, default 4: enemy slots managed.
REQ-002 SHALL have parameter IDX_W, default 2: slot index width, 2^IDX_W >= ENEMY_NUM.
REQ-003 SHALL have parameter HP, default 3: bullet hits to kill; HP_W default 2.
REQ-004 SHALL have parameter DOWN_FRAMES, default 3: explosion frames (>=1).
REQ-005 SHALL have parameter CNT_DOWN_MAX, default 1000000: clk_vga cycles per frame tick; CNT_W default 20.
REQ-006 SHALL have parameter GRAY_W, default 4, and SCORE_W, default 3.
REQ-007 clk_vga  in  1  pixel/system clock.
REQ-008 rst  in  1  reset; asynchronous, active-high.
REQ-009 vali_i  in  1  pixel request lies inside slot curr_idx_i's box.
REQ-010 curr_idx_i  in  IDX_W  slot owning the current pixel.
REQ-011 hit_i  in  1  bullet collided with slot curr_idx_i.
REQ-012 crash_me_i  in  1  player collided with slot curr_idx_i.
REQ-013 bomb_i  in  1  kill all live enemies.
REQ-014 trigger_i / trigger_idx_i  in  1 / IDX_W  spawn request for one slot.
REQ-015 sprite_i  in  (DOWN_FRAMES+2)*(1+GRAY_W)  BRAM word, MSB first {alpha,gray}: normal, hit, down1..downN.
REQ-016 vga_alpha_o / vga_rgb_o  out  1 / 3*GRAY_W  pixel alpha and grey replicated to R,G,B.
REQ-017 disappear_o  out  ENEMY_NUM  per-slot one-cycle explosion-done pulse.
REQ-018 add_score_o  out  SCORE_W  popcount of disappear_o.
REQ-019 live_o  out  ENEMY_NUM  slot is in NORMAL or HIT.

Function
REQ-020 Each slot SHALL hold state IDLE, NORMAL, HIT, DOWN plus hp (HP_W) and frame index (down frame 0..DOWN_FRAMES-1).
REQ-021 Free-running counter SHALL count 0..CNT_DOWN_MAX-1, wrap, and register tick=1 for exactly one cycle per wrap.
REQ-022 IDLE -> NORMAL with hp=HP when trigger_i and trigger_idx_i==slot; trigger on non-IDLE slot ignored.
REQ-023 Slot is "addressed" when vali_i and curr_idx_i==slot and curr_idx_i<ENEMY_NUM; hit_i/crash_me_i otherwise ignored.
REQ-024 NORMAL/HIT, addressed crash_me_i -> DOWN frame 0 regardless of hp.
REQ-025 NORMAL/HIT, addressed hit_i: hp==1 -> DOWN frame 0; else hp decremented, NORMAL -> HIT.
REQ-026 HIT -> NORMAL on tick when no kill event that cycle.
REQ-027 bomb_i SHALL send every NORMAL/HIT slot to DOWN frame 0; bomb has priority over hit/crash; DOWN/IDLE slots unaffected.
REQ-028 DOWN: on tick frame increments; at frame DOWN_FRAMES-1 with tick -> IDLE and disappear_o[slot]=1 that cycle (combinational from registered state).
REQ-029 Entry to DOWN SHALL not itself advance the frame even if tick coincides.
REQ-030 Pixel output combinational, zero latency: !vali_i or IDLE -> alpha 0, rgb 0; NORMAL -> normal field; HIT -> hit field; DOWN k -> down(k+1) field.
REQ-031 add_score_o SHALL saturate at 2^SCORE_W-1.

Reset
REQ-032 rst SHALL force all slots IDLE, hp 0, frame 0, counter 0, tick 0; disappear_o, add_score_o, live_o, vga outputs 0.
REQ-033 rst mid-explosion SHALL produce no disappear_o pulse.

Configuration
REQ-034 Macro ENEMY_HIT_FLASH_EN: defined -> HIT state and hit sprite as REQ-025/026/030.
REQ-035 Undefined -> non-fatal hit only decrements hp, slot stays NORMAL, HIT never entered, hit field ignored.

Verification
REQ-036 Reset then trigger idx 2 -> live_o=4'b0100, hp=3; vali_i idx 2 -> normal sprite pixel.
REQ-037 Three addressed hits on slot 2 -> after 3rd, DOWN; CNT_DOWN_MAX=4: disappear_o=4'b0100, add_score_o=1 exactly 3 ticks later.
REQ-038 Slots 0,1 NORMAL, slot 3 DOWN; bomb_i plus hit_i idx 0 same cycle -> 0,1 DOWN, slot 3 frame unchanged; later add_score_o=2 when 0,1 finish together.
REQ-039 hit_i with vali_i=0, or curr_idx_i=3 when slot 3 IDLE -> no state change; trigger idx 1 while slot 1 DOWN -> ignored.
REQ-040 With ENEMY_HIT_FLASH_EN: one hit -> hit sprite until next tick, then normal; without: normal sprite throughout, hp=2.
REQ-041 rst asserted during DOWN frame 1 -> all IDLE, disappear_o stays 0.
